// File: rtl/uart_pkg.sv
// Shared UART receive-side types: channel index and per-channel holding register.
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_MAX_CH = 16;

  typedef logic [$clog2(UART_MAX_CH)-1:0] ch_idx_t;

  typedef struct packed {
    logic [UART_DATA_W-1:0] data;
    logic                   full;
    logic                   ovr;
  } hold_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: searches last+1, last+2, ... for the first requester.
// The last-grant pointer only moves when the grant is actually taken.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         req,
  input  logic                 advance,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any_req
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] last;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

  assign any_req = |req;

  // Pointer starts at N-1 so channel 0 is searched first after reset.
  always_ff @(posedge clock) begin
    if (reset)
      last <= IW'(N - 1);
    else if (advance && any_req)
      last <= gnt_idx;
  end
endmodule

// File: rtl/uart_rx_arbiter.sv
// Merges NUM_CH UART receiver byte streams into one tagged valid/ready stream,
// with a one-byte holding register and overrun tracking per channel.
module uart_rx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  localparam int CH_W  = $clog2(NUM_CH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        ch_done,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_overrun,
  output logic [NUM_CH-1:0]        overrun_sticky,
  input  logic [NUM_CH-1:0]        clr_overrun
);
  hold_t             hold_q [NUM_CH];
  logic [NUM_CH-1:0] hold_req;
  logic [NUM_CH-1:0] gnt;
  logic [CH_W-1:0]   gnt_idx;
  ch_idx_t           gnt_ch;
  logic              any_req;
  logic              slot_free;
  logic              take;
  logic [NUM_CH-1:0] popped;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      hold_req[i] = hold_q[i].full;
  end

  assign slot_free = !out_valid || out_ready;
  assign take      = slot_free && any_req;
  assign popped    = take ? gnt : '0;
  assign gnt_ch    = ch_idx_t'(gnt_idx);

  rr_arbiter #(.N(NUM_CH)) u_rr (
    .clock   (clock),
    .reset   (reset),
    .req     (hold_req),
    .advance (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any_req (any_req)
  );

  // Capture: a popped register can accept a new byte on the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++)
        hold_q[i] <= '0;
      overrun_sticky <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_done[i] && (!hold_q[i].full || popped[i])) begin
          hold_q[i].data <= UART_DATA_W'(ch_data[i*DATA_W +: DATA_W]);
          hold_q[i].full <= 1'b1;
          hold_q[i].ovr  <= 1'b0;
        end else if (ch_done[i]) begin
          hold_q[i].ovr  <= 1'b1;
        end else if (popped[i]) begin
          hold_q[i].full <= 1'b0;
        end

        if (ch_done[i] && hold_q[i].full && !popped[i])
          overrun_sticky[i] <= 1'b1;
        else if (clr_overrun[i])
          overrun_sticky[i] <= 1'b0;
      end
    end
  end

  // Output slot: reloads on the accepting edge for back-to-back throughput.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      out_overrun <= 1'b0;
    end else if (slot_free) begin
      if (any_req) begin
        out_valid   <= 1'b1;
        out_data    <= DATA_W'(hold_q[gnt_idx].data);
        out_ch      <= CH_W'(gnt_ch);
        out_overrun <= hold_q[gnt_idx].ovr;
      end else begin
        out_valid   <= 1'b0;
      end
    end
  end
endmodule
